fan_ctrl_param: RTL and testbench

- Parametrised successor to the current fan top-level control logic.
- Provides N-level motor power with soft-start ramp and an auto-off countdown timer with selectable presets.
- Provides an independent M-level light dimmer and two PWM outputs with configurable resolution and frequency.
- Sits between the button debouncers (single-cycle edge pulses) and the motor/light drivers. Also exports remaining time for the 4-digit FND driver and LED indicators.

---
 rtl/fan_ctrl_param_if.sv | 32 +++
 rtl/fan_ctrl_param.sv | 157 +++++++++++++++
 tb/tb_fan_ctrl_param.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fan_ctrl_param_if.sv
// Button pulses in, motor/light drive and front-panel status out.
// The controller takes the slave side; whatever drives the buttons takes the master side.
interface fan_ctrl_param_if #(
    parameter int POWER_LEVELS = 3,
    parameter int PWM_BITS     = 7,
    parameter int TIMER_W      = 16
);
    logic                    btn_power_pe;
    logic                    btn_timer_pe;
    logic                    btn_light_pe;
    logic                    motor_pwm;
    logic                    light_pwm;
    logic [2:0]              power_level;
    logic [2:0]              light_level;
    logic [1:0]              timer_mode;
    logic [TIMER_W-1:0]      timer_remain;
    logic [POWER_LEVELS-1:0] led_power;
    logic [2:0]              led_timer;
    logic [PWM_BITS-1:0]     duty_motor;

    modport master (
        output btn_power_pe, btn_timer_pe, btn_light_pe,
        input  motor_pwm, light_pwm, power_level, light_level, timer_mode,
               timer_remain, led_power, led_timer, duty_motor
    );

    modport slave (
        input  btn_power_pe, btn_timer_pe, btn_light_pe,
        output motor_pwm, light_pwm, power_level, light_level, timer_mode,
               timer_remain, led_power, led_timer, duty_motor
    );
endinterface

// File: rtl/fan_ctrl_param.sv
// Fan controller: stepped motor power with soft-start ramp, auto-off timer,
// independent light dimmer and the two PWM generators driving them.
module fan_ctrl_param #(
    parameter int POWER_LEVELS   = 3,
    parameter int LIGHT_LEVELS   = 3,
    parameter int PWM_BITS       = 7,
    parameter int PWM_DIV        = 7813,
    parameter int SEC_DIV        = 100_000_000,
    parameter int TIMER_UNIT_SEC = 60,
    parameter int TIMER_W        = 16,
    parameter int RAMP_DIV       = 100_000
) (
    input logic             clk,
    input logic             reset_p,
    fan_ctrl_param_if.slave bus
);
    localparam int STEP_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int SEC_W  = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
    localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned DUTY_MAX = (1 << PWM_BITS) - 1;

    function automatic logic [PWM_BITS-1:0] level_duty(input logic [2:0] level, input int levels);
        int unsigned prod;
        prod = 32'(level) * DUTY_MAX;
        return PWM_BITS'(prod / levels);
    endfunction

    logic [2:0]          power_level;
    logic [2:0]          light_level;
    logic [1:0]          timer_mode;
    logic [TIMER_W-1:0]  timer_remain;
    logic [PWM_BITS-1:0] duty_motor;
    logic [SEC_W-1:0]    sec_cnt;
    logic [RAMP_W-1:0]   ramp_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                motor_pwm;
    logic                light_pwm;

    logic [2:0]          power_next;
    logic [1:0]          mode_next;
    logic [PWM_BITS-1:0] motor_target;
    logic [PWM_BITS-1:0] light_duty;
    logic                sec_tick;
    logic                expiry;

    always_comb begin
        power_next = power_level;
        if (bus.btn_power_pe)
            power_next = (power_level == 3'(POWER_LEVELS)) ? 3'd0 : power_level + 3'd1;
    end

    assign mode_next    = timer_mode + 2'd1;
    assign motor_target = level_duty(power_level, POWER_LEVELS);
    assign light_duty   = level_duty(light_level, LIGHT_LEVELS);
    assign sec_tick     = (timer_mode != 2'd0) && (power_level != 3'd0) &&
                          (sec_cnt == SEC_W'(SEC_DIV - 1));
    assign expiry       = sec_tick && (timer_remain == TIMER_W'(1));

    // Expiry outranks the buttons; a power press is resolved before the timer press sees the level.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            power_level  <= '0;
            timer_mode   <= '0;
            timer_remain <= '0;
            sec_cnt      <= '0;
        end else if (expiry) begin
            power_level  <= '0;
            timer_mode   <= '0;
            timer_remain <= '0;
            sec_cnt      <= '0;
        end else begin
            power_level <= power_next;
            if (bus.btn_power_pe && power_next == 3'd0) begin
                timer_mode   <= '0;
                timer_remain <= '0;
                sec_cnt      <= '0;
            end else if (bus.btn_timer_pe && power_next != 3'd0) begin
                timer_mode <= mode_next;
                sec_cnt    <= '0;
                case (mode_next)
                    2'd1:    timer_remain <= TIMER_W'(TIMER_UNIT_SEC);
                    2'd2:    timer_remain <= TIMER_W'(3 * TIMER_UNIT_SEC);
                    2'd3:    timer_remain <= TIMER_W'(5 * TIMER_UNIT_SEC);
                    default: timer_remain <= '0;
                endcase
            end else if (timer_mode != 2'd0 && power_level != 3'd0) begin
                if (sec_tick) begin
                    sec_cnt      <= '0;
                    timer_remain <= timer_remain - TIMER_W'(1);
                end else begin
                    sec_cnt <= sec_cnt + SEC_W'(1);
                end
            end
        end
    end

    // Soft start only slows increases; any decrease snaps straight to the new target.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            duty_motor <= '0;
            ramp_cnt   <= '0;
        end else if (duty_motor < motor_target) begin
            if (ramp_cnt == RAMP_W'(RAMP_DIV - 1)) begin
                duty_motor <= duty_motor + PWM_BITS'(1);
                ramp_cnt   <= '0;
            end else begin
                ramp_cnt <= ramp_cnt + RAMP_W'(1);
            end
        end else begin
            duty_motor <= motor_target;
            ramp_cnt   <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p)
            light_level <= '0;
        else if (bus.btn_light_pe)
            light_level <= (light_level == 3'(LIGHT_LEVELS)) ? 3'd0 : light_level + 3'd1;
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            step_cnt  <= '0;
            pwm_cnt   <= '0;
            motor_pwm <= 1'b0;
            light_pwm <= 1'b0;
        end else begin
            if (step_cnt == STEP_W'(PWM_DIV - 1)) begin
                step_cnt <= '0;
                pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
            end else begin
                step_cnt <= step_cnt + STEP_W'(1);
            end
            motor_pwm <= (pwm_cnt < duty_motor);
            light_pwm <= (pwm_cnt < light_duty);
        end
    end

    always_comb begin
        bus.led_power = '0;
        for (int k = 1; k <= POWER_LEVELS; k++)
            bus.led_power[k-1] = (power_level == 3'(k));
        bus.led_timer = '0;
        for (int k = 1; k <= 3; k++)
            bus.led_timer[k-1] = (timer_mode == 2'(k));
    end

    assign bus.power_level  = power_level;
    assign bus.light_level  = light_level;
    assign bus.timer_mode   = timer_mode;
    assign bus.timer_remain = timer_remain;
    assign bus.duty_motor   = duty_motor;
    assign bus.motor_pwm    = motor_pwm;
    assign bus.light_pwm    = light_pwm;
endmodule

// File: tb/tb_fan_ctrl_param.sv
// Bench for fan_ctrl_param: directed vector table, multi-cycle corner sequences
// and a random run checked every cycle against an elapsed-time reference model.
module tb_fan_ctrl_param;
    localparam int POWER_LEVELS   = 3;
    localparam int LIGHT_LEVELS   = 3;
    localparam int PWM_BITS       = 4;
    localparam int PWM_DIV        = 1;
    localparam int SEC_DIV        = 10;
    localparam int TIMER_UNIT_SEC = 2;
    localparam int TIMER_W        = 16;
    localparam int RAMP_DIV       = 2;
    localparam int PERIOD         = 1 << PWM_BITS;

    logic clk = 1'b0;
    logic reset_p = 1'b1;
    int   checks = 0;
    int   failures = 0;

    fan_ctrl_param_if #(.POWER_LEVELS(POWER_LEVELS), .PWM_BITS(PWM_BITS), .TIMER_W(TIMER_W)) bus ();

    fan_ctrl_param #(
        .POWER_LEVELS(POWER_LEVELS), .LIGHT_LEVELS(LIGHT_LEVELS), .PWM_BITS(PWM_BITS),
        .PWM_DIV(PWM_DIV), .SEC_DIV(SEC_DIV), .TIMER_UNIT_SEC(TIMER_UNIT_SEC),
        .TIMER_W(TIMER_W), .RAMP_DIV(RAMP_DIV)
    ) dut (
        .clk(clk),
        .reset_p(reset_p),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference state: the timer is tracked as edges elapsed since the last load.
    int m_power, m_light, m_mode, m_preset, m_elapsed;
    int m_duty, m_ramp_acc, edge_n;
    bit m_motor_pwm, m_light_pwm;

    function automatic int duty_of(input int lvl, input int levels);
        return lvl * (PERIOD - 1) / levels;
    endfunction

    task automatic model_reset();
        m_power = 0; m_light = 0; m_mode = 0; m_preset = 0; m_elapsed = 0;
        m_duty = 0; m_ramp_acc = 0; edge_n = 0;
        m_motor_pwm = 1'b0; m_light_pwm = 1'b0;
    endtask

    task automatic model_edge(input bit p, input bit t, input bit l);
        int cnt_old;
        int tgt_old;
        cnt_old     = (edge_n / PWM_DIV) % PERIOD;
        m_motor_pwm = (cnt_old < m_duty);
        m_light_pwm = (cnt_old < duty_of(m_light, LIGHT_LEVELS));
        tgt_old     = duty_of(m_power, POWER_LEVELS);
        if (m_duty < tgt_old) begin
            m_ramp_acc++;
            if (m_ramp_acc == RAMP_DIV) begin
                m_duty++;
                m_ramp_acc = 0;
            end
        end else begin
            m_duty = tgt_old;
            m_ramp_acc = 0;
        end
        edge_n++;
        if (l) m_light = (m_light + 1) % (LIGHT_LEVELS + 1);
        if (m_mode != 0 && m_elapsed + 1 == m_preset * SEC_DIV) begin
            m_mode = 0;
            m_power = 0;
            m_elapsed = 0;
        end else begin
            if (m_mode != 0) m_elapsed++;
            if (p) begin
                m_power = (m_power + 1) % (POWER_LEVELS + 1);
                if (m_power == 0) m_mode = 0;
            end
            if (t && m_power != 0) begin
                m_mode = (m_mode + 1) % 4;
                m_elapsed = 0;
                m_preset = (m_mode == 1) ? TIMER_UNIT_SEC :
                           (m_mode == 2) ? 3 * TIMER_UNIT_SEC : 5 * TIMER_UNIT_SEC;
            end
        end
    endtask

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        compare("power_level", 64'(bus.power_level), 64'(m_power));
        compare("light_level", 64'(bus.light_level), 64'(m_light));
        compare("timer_mode", 64'(bus.timer_mode), 64'(m_mode));
        compare("timer_remain", 64'(bus.timer_remain),
                64'((m_mode == 0) ? 0 : m_preset - m_elapsed / SEC_DIV));
        compare("led_power", 64'(bus.led_power), 64'((m_power == 0) ? 0 : (1 << (m_power - 1))));
        compare("led_timer", 64'(bus.led_timer), 64'((m_mode == 0) ? 0 : (1 << (m_mode - 1))));
        compare("duty_motor", 64'(bus.duty_motor), 64'(m_duty));
        compare("motor_pwm", 64'(bus.motor_pwm), 64'(m_motor_pwm));
        compare("light_pwm", 64'(bus.light_pwm), 64'(m_light_pwm));
    endtask

    task automatic applyStimulus(input bit p, input bit t, input bit l);
        bus.btn_power_pe = p;
        bus.btn_timer_pe = t;
        bus.btn_light_pe = l;
        @(posedge clk);
        model_edge(p, t, l);
        @(negedge clk);
        bus.btn_power_pe = 1'b0;
        bus.btn_timer_pe = 1'b0;
        bus.btn_light_pe = 1'b0;
        checkOutput();
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_dut();
        bus.btn_power_pe = 1'b0;
        bus.btn_timer_pe = 1'b0;
        bus.btn_light_pe = 1'b0;
        reset_p = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_p = 1'b0;
        model_reset();
    endtask

    // Back-to-back presses to level 3, then off; 15 ramp steps of RAMP_DIV cycles from the first press.
    task automatic ramp_sequence();
        int n;
        int highs;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        compare("ramp_level3", 64'(bus.power_level), 64'd3);
        compare("ramp_led3", 64'(bus.led_power), 64'b100);
        n = 2;
        while (bus.duty_motor != 4'd15 && n < 100) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            n++;
        end
        compare("ramp_cycles", 64'(n), 64'd30);
        applyStimulus(1'b1, 1'b0, 1'b0);
        compare("off_level", 64'(bus.power_level), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        compare("off_duty", 64'(bus.duty_motor), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        highs = 0;
        repeat (20) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            highs += int'(bus.motor_pwm);
        end
        compare("off_pwm_highs", 64'(highs), 64'd0);
    endtask

    typedef struct {
        bit       p, t, l;
        int       e_power, e_mode, e_remain, e_light;
        bit [2:0] e_led_p, e_led_t;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int highs;
        bus.btn_power_pe = 1'b0;
        bus.btn_timer_pe = 1'b0;
        bus.btn_light_pe = 1'b0;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 3'b001, 3'b000};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1, 1, 2, 0, 3'b001, 3'b001};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1, 2, 6, 0, 3'b001, 3'b010};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1, 2, 6, 1, 3'b001, 3'b010};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1, 2, 6, 2, 3'b001, 3'b010};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1, 3, 10, 2, 3'b001, 3'b100};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1, 0, 0, 2, 3'b001, 3'b000};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 2, 0, 0, 2, 3'b010, 3'b000};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 3, 0, 0, 2, 3'b100, 3'b000};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 0, 0, 0, 2, 3'b000, 3'b000};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 2, 3'b000, 3'b000};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 0, 0, 0, 3, 3'b000, 3'b000};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 3'b000, 3'b000};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1, 1, 2, 0, 3'b001, 3'b001};

        reset_dut();
        compare("reset_power", 64'(bus.power_level), 64'd0);
        compare("reset_remain", 64'(bus.timer_remain), 64'd0);
        compare("reset_duty", 64'(bus.duty_motor), 64'd0);
        compare("reset_motor_pwm", 64'(bus.motor_pwm), 64'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].p, vecs[i].t, vecs[i].l);
            compare($sformatf("vec%0d_power", i), 64'(bus.power_level), 64'(vecs[i].e_power));
            compare($sformatf("vec%0d_mode", i), 64'(bus.timer_mode), 64'(vecs[i].e_mode));
            compare($sformatf("vec%0d_remain", i), 64'(bus.timer_remain), 64'(vecs[i].e_remain));
            compare($sformatf("vec%0d_light", i), 64'(bus.light_level), 64'(vecs[i].e_light));
            compare($sformatf("vec%0d_led_power", i), 64'(bus.led_power), 64'(vecs[i].e_led_p));
            compare($sformatf("vec%0d_led_timer", i), 64'(bus.led_timer), 64'(vecs[i].e_led_t));
        end

        reset_dut();
        ramp_sequence();

        // Steady level 1 gives 5/16 motor duty; two light presses give 10/16 with no ramp.
        reset_dut();
        applyStimulus(1'b1, 1'b0, 1'b0);
        idle(20);
        compare("lvl1_duty", 64'(bus.duty_motor), 64'd5);
        highs = 0;
        repeat (16) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            highs += int'(bus.motor_pwm);
        end
        compare("lvl1_motor_highs", 64'(highs), 64'd5);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        idle(2);
        highs = 0;
        repeat (16) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            highs += int'(bus.light_pwm);
        end
        compare("light2_highs", 64'(highs), 64'd10);

        // Mode 2 at level 2 runs out after 60 cycles; light survives expiry.
        reset_dut();
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        compare("m2_remain", 64'(bus.timer_remain), 64'd6);
        compare("m2_led_timer", 64'(bus.led_timer), 64'b010);
        idle(59);
        compare("m2_pre_mode", 64'(bus.timer_mode), 64'd2);
        compare("m2_pre_remain", 64'(bus.timer_remain), 64'd1);
        idle(1);
        compare("m2_exp_remain", 64'(bus.timer_remain), 64'd0);
        compare("m2_exp_mode", 64'(bus.timer_mode), 64'd0);
        compare("m2_exp_power", 64'(bus.power_level), 64'd0);
        compare("m2_exp_light", 64'(bus.light_level), 64'd1);

        // Power press landing on the expiry edge is dropped.
        reset_dut();
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        compare("m1_remain", 64'(bus.timer_remain), 64'd2);
        idle(19);
        applyStimulus(1'b1, 1'b0, 1'b0);
        compare("m1_exp_power", 64'(bus.power_level), 64'd0);
        compare("m1_exp_mode", 64'(bus.timer_mode), 64'd0);

        // Power cycled to 0 during mode 3 kills the timer; re-powering does not restart it.
        reset_dut();
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
        idle(15);
        compare("m3_remain", 64'(bus.timer_remain), 64'd9);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        compare("m3_lvl3_mode", 64'(bus.timer_mode), 64'd3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        compare("m3_off_mode", 64'(bus.timer_mode), 64'd0);
        compare("m3_off_remain", 64'(bus.timer_remain), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        idle(30);
        compare("m3_repower_level", 64'(bus.power_level), 64'd1);
        compare("m3_repower_mode", 64'(bus.timer_mode), 64'd0);
        compare("m3_repower_remain", 64'(bus.timer_remain), 64'd0);

        // Reset asserted between edges while ramping and counting down.
        reset_dut();
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        idle(5);
        #2 reset_p = 1'b1;
        #1;
        model_reset();
        checkOutput();
        compare("async_led_power", 64'(bus.led_power), 64'd0);
        compare("async_led_timer", 64'(bus.led_timer), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_p = 1'b0;
        model_reset();
        ramp_sequence();

        reset_dut();
        for (int i = 0; i < 4000; i++) begin
            applyStimulus($urandom_range(29) == 0, $urandom_range(39) == 0, $urandom_range(19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
